// File: rtl/pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module : pio_in_edge_irq
// Brief  : Avalon-MM input PIO with synchronised level readback, sticky edge
//          capture and masked level interrupt.
// Rev    : 1.0
// ============================================================================
module pio_in_edge_irq #(
   parameter int               WIDTH      = 4,
   parameter int               EDGE_TYPE  = 0,
   parameter int               BIT_CLEAR  = 1,
   parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_CAP  = 2'd3;
   localparam logic [1:0] ARM_DONE  = 2'd3;

   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [WIDTH-1:0] s3_q, s3_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [1:0]       arm_q, arm_d;

   logic             wr_en, wr_mask, wr_cap;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] edge_raw, edge_vec, cap_clr;
   logic [31:0]      unused_wdata;

   // Only the low WIDTH bits of writedata carry register content.
   assign unused_wdata = writedata;
   assign wdata        = writedata[WIDTH-1:0];

   assign wr_en   = chipselect & ~write_n;
   assign wr_mask = wr_en && (address == ADDR_MASK);
   assign wr_cap  = wr_en && (address == ADDR_CAP);

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign edge_raw = s2_q & ~s3_q;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign edge_raw = ~s2_q & s3_q;
      end else begin : g_any
         assign edge_raw = s2_q ^ s3_q;
      end
   endgenerate

   generate
      if (BIT_CLEAR != 0) begin : g_bit_clear
         assign cap_clr = wr_cap ? wdata : '0;
      end else begin : g_all_clear
         assign cap_clr = {WIDTH{wr_cap}};
      end
   endgenerate

   // Edges are suppressed until the sync pipeline holds real samples, so a
   // line already high at reset does not look like a fresh edge.
   assign edge_vec = (arm_q == ARM_DONE) ? edge_raw : '0;

   always_comb begin
      s1_d   = in_port;
      s2_d   = s1_q;
      s3_d   = s2_q;
      arm_d  = (arm_q == ARM_DONE) ? arm_q : arm_q + 2'd1;
      mask_d = wr_mask ? wdata : mask_q;
      // A new edge beats a same-cycle clear of that bit.
      cap_d  = edge_vec | (cap_q & ~cap_clr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         s3_q   <= '0;
         arm_q  <= '0;
         cap_q  <= '0;
         mask_q <= RESET_MASK;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         s3_q   <= s3_d;
         arm_q  <= arm_d;
         cap_q  <= cap_d;
         mask_q <= mask_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA: readdata[WIDTH-1:0] = s2_q;
         ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
         ADDR_CAP:  readdata[WIDTH-1:0] = cap_q;
         default:   readdata = '0;
      endcase
   end

   assign irq = |(cap_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module : tb_pio_in_edge_irq
// Brief  : Directed self-checking bench; dut uses rising/bit-clear defaults,
//          dut2 uses any-edge, clear-all and a non-zero reset mask.
// Rev    : 1.0
// ============================================================================
module tb_pio_in_edge_irq;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect, chipselect2;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port, in_port2;
   logic [31:0] readdata, readdata2;
   logic        irq, irq2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pio_in_edge_irq #(
      .WIDTH(4), .EDGE_TYPE(0), .BIT_CLEAR(1), .RESET_MASK(4'h0)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   pio_in_edge_irq #(
      .WIDTH(4), .EDGE_TYPE(2), .BIT_CLEAR(0), .RESET_MASK(4'h5)
   ) dut2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect2),
      .write_n(write_n), .writedata(writedata), .in_port(in_port2),
      .readdata(readdata2), .irq(irq2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input bit sel2, input logic [1:0] a, input logic [31:0] d);
      address     = a;
      writedata   = d;
      chipselect  = !sel2;
      chipselect2 = sel2;
      write_n     = 1'b0;
      tick();
      chipselect  = 1'b0;
      chipselect2 = 1'b0;
      write_n     = 1'b1;
      writedata   = '0;
   endtask

   task automatic bus_read(input bit sel2, input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = sel2 ? readdata2 : readdata;
   endtask

   logic [31:0] rd;

   initial begin
      reset = 1'b1; address = '0; chipselect = 1'b0; chipselect2 = 1'b0;
      write_n = 1'b1; writedata = '0; in_port = 4'hF; in_port2 = 4'h0;
      tick(2);
      reset = 1'b0;

      // Reset state, input held high through reset
      bus_read(0, 2'd0, rd); check("rst_data", rd, 32'h0);
      bus_read(0, 2'd2, rd); check("rst_mask", rd, 32'h0);
      bus_read(0, 2'd3, rd); check("rst_cap", rd, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      bus_read(1, 2'd2, rd); check("rst_mask2", rd, 32'h5);
      tick();
      bus_read(0, 2'd0, rd); check("data_lat1", rd, 32'h0);
      tick();
      bus_read(0, 2'd0, rd); check("data_lat2", rd, 32'hF);
      tick(4);
      bus_read(0, 2'd3, rd); check("held_no_cap", rd, 32'h0);
      check("held_no_irq", {31'b0, irq}, 32'h0);

      // Single rising edge, masked in, then write-1 clear
      in_port = 4'h0;
      tick(4);
      bus_write(0, 2'd2, 32'h2);
      in_port = 4'h2;
      tick(2);
      bus_read(0, 2'd3, rd); check("cap_k1", rd, 32'h0);
      check("irq_k1", {31'b0, irq}, 32'h0);
      tick();
      bus_read(0, 2'd3, rd); check("cap_k2", rd, 32'h2);
      check("irq_k2", {31'b0, irq}, 32'h1);
      bus_write(0, 2'd3, 32'h2);
      bus_read(0, 2'd3, rd); check("cap_clr", rd, 32'h0);
      check("irq_clr", {31'b0, irq}, 32'h0);

      // Two edges with mask 0, then late mask write and partial clear
      bus_write(0, 2'd2, 32'h0);
      in_port = 4'hB;
      tick(3);
      bus_read(0, 2'd3, rd); check("cap_b03", rd, 32'h9);
      check("irq_masked", {31'b0, irq}, 32'h0);
      bus_write(0, 2'd2, 32'hFFFF_FFF8);
      bus_read(0, 2'd2, rd); check("mask_rd", rd, 32'h8);
      check("irq_unmask", {31'b0, irq}, 32'h1);
      bus_write(0, 2'd3, 32'h1);
      bus_read(0, 2'd3, rd); check("cap_part", rd, 32'h8);
      check("irq_part", {31'b0, irq}, 32'h1);

      // Edge on bit0 coincides with a write-1 clear of bit0
      in_port = 4'hA;
      tick(3);
      in_port = 4'hB;
      tick(2);
      bus_write(0, 2'd3, 32'h1);
      bus_read(0, 2'd3, rd); check("edge_wins", rd, 32'h9);
      bus_write(0, 2'd3, 32'h1);
      bus_read(0, 2'd3, rd); check("clr_after", rd, 32'h8);

      // Any-edge, clear-all instance
      in_port2 = 4'h4;
      tick(3);
      bus_read(1, 2'd3, rd); check("any_rise", rd, 32'h4);
      check("irq2_rise", {31'b0, irq2}, 32'h1);
      bus_write(1, 2'd3, 32'h0);
      bus_read(1, 2'd3, rd); check("any_clr0", rd, 32'h0);
      in_port2 = 4'h0;
      tick(3);
      bus_read(1, 2'd3, rd); check("any_fall", rd, 32'h4);
      bus_write(1, 2'd3, 32'h0);
      bus_read(1, 2'd3, rd); check("any_clr1", rd, 32'h0);
      check("irq2_clr", {31'b0, irq2}, 32'h0);

      // Full pending state, then reset with a concurrent mask write
      bus_write(0, 2'd2, 32'hF);
      in_port = 4'h0;
      tick(3);
      in_port = 4'hF;
      tick(3);
      bus_read(0, 2'd3, rd); check("cap_full", rd, 32'hF);
      check("irq_full", {31'b0, irq}, 32'h1);
      reset = 1'b1;
      bus_write(0, 2'd2, 32'hF);
      reset = 1'b0;
      bus_read(0, 2'd3, rd); check("mid_rst_cap", rd, 32'h0);
      bus_read(0, 2'd2, rd); check("mid_rst_mask", rd, 32'h0);
      check("mid_rst_irq", {31'b0, irq}, 32'h0);
      tick(5);
      bus_read(0, 2'd3, rd); check("post_rst_cap", rd, 32'h0);

      // Read-only / unused addresses and deselected writes
      bus_write(0, 2'd0, 32'h5);
      bus_write(0, 2'd1, 32'h5);
      bus_read(0, 2'd0, rd); check("addr0_ro", rd, 32'hF);
      bus_read(0, 2'd1, rd); check("addr1_zero", rd, 32'h0);
      address = 2'd2; writedata = 32'hF; write_n = 1'b0;
      tick();
      write_n = 1'b1;
      bus_read(0, 2'd2, rd); check("cs_low_mask", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
